// File: rtl/omsp_hmac_arbiter.sv
// Two-client arbiter for the shared HMAC/SPONGENT core: grants, muxes, and scrubs the core on every handover.
// Optional client-1 idle timeout is compiled in with `define HMAC_ARB_TIMEOUT_EN.
module omsp_hmac_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TO_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  ctl0,
  input  logic [3:0]  ctl1,
  input  logic [15:0] dat0,
  input  logic [15:0] dat1,
  input  logic [1:0]  key0,
  input  logic [1:0]  key1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        busy0,
  output logic        busy1,
  output logic        abort1,
  input  logic        hmac_busy,
  output logic [3:0]  hmac_ctl,
  output logic [15:0] hmac_data,
  output logic [1:0]  hmac_key,
  output logic [2:0]  dbg_state
);

  // Handshake: reqx is a level held for the whole session; gntx rises one clock after
  // reqx is seen in IDLE and stays high until reqx drops (or a timeout revokes client 1).
  typedef enum logic [2:0] {S_IDLE, S_OWN0, S_OWN1, S_DRAIN, S_SCRUB} state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;
  logic   req1_eff;
  logic   to_fire;

  if (TO_CYCLES < 2 || TO_CYCLES > 65536) begin : g_bad_to_cycles
    $error("TO_CYCLES must be in 2..65536");
  end

`ifdef HMAC_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        lock_q, lock_d;
  logic        abort1_q, abort1_d;
  logic        c1_idle;

  always_comb begin
    c1_idle  = (ctl1[2:1] == 2'b00) && !hmac_busy;
    // Release takes priority over timeout, so the timeout only fires while req1 is still high.
    to_fire  = (state_q == S_OWN1) && req1 && c1_idle && (cnt_q == TO_LAST);
    cnt_d    = 16'd0;
    if (state_q == S_OWN1 && c1_idle && !to_fire) cnt_d = cnt_q + 16'd1;
    lock_d   = to_fire | (lock_q & req1);
    abort1_d = to_fire;
    req1_eff = req1 & ~lock_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 16'd0;
      lock_q   <= 1'b0;
      abort1_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      lock_q   <= lock_d;
      abort1_q <= abort1_d;
    end
  end

  assign abort1 = abort1_q;
`else
  assign req1_eff = req1;
  assign to_fire  = 1'b0;
  assign abort1   = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    busy0     = 1'b1;
    busy1     = 1'b1;
    hmac_ctl  = 4'b1000;
    hmac_data = 16'h0000;
    hmac_key  = 2'b00;
    case (state_q)
      S_IDLE: begin
        if (req0 && req1_eff) begin
          if (FIXED_PRIO == 0 && !last_q) begin
            state_d = S_OWN1;
            last_d  = 1'b1;
          end else begin
            state_d = S_OWN0;
            last_d  = 1'b0;
          end
        end else if (req0) begin
          state_d = S_OWN0;
          last_d  = 1'b0;
        end else if (req1_eff) begin
          state_d = S_OWN1;
          last_d  = 1'b1;
        end
      end
      S_OWN0: begin
        gnt0      = 1'b1;
        busy0     = hmac_busy;
        hmac_ctl  = ctl0;
        hmac_data = dat0;
        hmac_key  = key0;
        if (!req0) state_d = hmac_busy ? S_DRAIN : S_SCRUB;
      end
      S_OWN1: begin
        gnt1      = 1'b1;
        busy1     = hmac_busy;
        hmac_ctl  = ctl1;
        hmac_data = dat1;
        hmac_key  = key1;
        if (!req1)        state_d = hmac_busy ? S_DRAIN : S_SCRUB;
        else if (to_fire) state_d = S_SCRUB;
      end
      S_DRAIN: begin
        hmac_ctl = 4'b0000;
        if (!hmac_busy) state_d = S_SCRUB;
      end
      S_SCRUB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_omsp_hmac_arbiter.sv
// Bench for omsp_hmac_arbiter: a round-robin and a fixed-priority instance share one stimulus,
// each checked every cycle against a session-level model, plus directed literal checks.
module tb_omsp_hmac_arbiter;
`ifdef HMAC_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, hmac_busy = 1'b0;
  logic [3:0]  ctl0 = '0, ctl1 = '0;
  logic [15:0] dat0 = '0, dat1 = '0;
  logic [1:0]  key0 = '0, key1 = '0;

  logic        gnt0_w [2], gnt1_w [2], busy0_w [2], busy1_w [2], abort1_w [2];
  logic [3:0]  ctl_w  [2];
  logic [15:0] data_w [2];
  logic [1:0]  key_w  [2];
  logic [2:0]  dbg_w  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    omsp_hmac_arbiter #(.FIXED_PRIO(g), .TO_CYCLES(TO)) u_dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1),
      .ctl0(ctl0), .ctl1(ctl1), .dat0(dat0), .dat1(dat1), .key0(key0), .key1(key1),
      .gnt0(gnt0_w[g]), .gnt1(gnt1_w[g]), .busy0(busy0_w[g]), .busy1(busy1_w[g]),
      .abort1(abort1_w[g]), .hmac_busy(hmac_busy), .hmac_ctl(ctl_w[g]),
      .hmac_data(data_w[g]), .hmac_key(key_w[g]), .dbg_state(dbg_w[g])
    );
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Session model: owner (-1 none), plus a draining flag and a one-cycle scrub flag.
  typedef struct packed {
    int own;
    bit drain;
    bit scrub;
    bit last;
    bit lock;
    bit abort;
    int idle_run;
  } model_t;

  model_t m [2];

  function automatic model_t model_reset();
    model_t n;
    n.own = -1; n.drain = 0; n.scrub = 0; n.last = 1; n.lock = 0; n.abort = 0; n.idle_run = 0;
    return n;
  endfunction

  function automatic model_t step(input model_t s, input bit prio);
    model_t n;
    bit r1;
    n = s;
    n.abort = 0;
    n.lock = s.lock && req1;
    if (s.scrub) n.scrub = 0;
    else if (s.drain) begin
      if (!hmac_busy) begin n.drain = 0; n.scrub = 1; end
    end else if (s.own >= 0) begin
      if (!((s.own == 0) ? req0 : req1)) begin
        n.own = -1;
        if (hmac_busy) n.drain = 1; else n.scrub = 1;
      end else if (TO_EN && s.own == 1) begin
        if (ctl1[2:1] != 2'b00 || hmac_busy) n.idle_run = 0;
        else if (s.idle_run == TO - 1) begin
          n.own = -1; n.scrub = 1; n.abort = 1; n.lock = 1; n.idle_run = 0;
        end else n.idle_run = s.idle_run + 1;
      end
    end else begin
      r1 = req1 && !s.lock;
      if (req0 && r1) n.own = (prio || s.last) ? 0 : 1;
      else if (req0)  n.own = 0;
      else if (r1)    n.own = 1;
      if (n.own >= 0) begin n.last = (n.own == 1); n.idle_run = 0; end
    end
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m[0] <= model_reset();
      m[1] <= model_reset();
    end else begin
      m[0] <= step(m[0], 1'b0);
      m[1] <= step(m[1], 1'b1);
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [3:0]  e_ctl;
      logic [15:0] e_dat;
      logic [1:0]  e_key;
      e_ctl = (m[i].own == 0) ? ctl0 : (m[i].own == 1) ? ctl1 : (m[i].drain ? 4'b0000 : 4'b1000);
      e_dat = (m[i].own == 0) ? dat0 : (m[i].own == 1) ? dat1 : 16'h0000;
      e_key = (m[i].own == 0) ? key0 : (m[i].own == 1) ? key1 : 2'b00;
      check($sformatf("cmp%0d_gnt0", i), 32'(gnt0_w[i]), 32'(m[i].own == 0));
      check($sformatf("cmp%0d_gnt1", i), 32'(gnt1_w[i]), 32'(m[i].own == 1));
      check($sformatf("cmp%0d_busy0", i), 32'(busy0_w[i]), 32'((m[i].own == 0) ? hmac_busy : 1'b1));
      check($sformatf("cmp%0d_busy1", i), 32'(busy1_w[i]), 32'((m[i].own == 1) ? hmac_busy : 1'b1));
      check($sformatf("cmp%0d_abort1", i), 32'(abort1_w[i]), 32'(m[i].abort));
      check($sformatf("cmp%0d_ctl", i), 32'(ctl_w[i]), 32'(e_ctl));
      check($sformatf("cmp%0d_data", i), 32'(data_w[i]), 32'(e_dat));
      check($sformatf("cmp%0d_key", i), 32'(key_w[i]), 32'(e_key));
    end
  end

  task automatic to_pos;
    @(posedge clk); #1;
  endtask

  task automatic to_neg;
    @(negedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    to_pos();
    reset = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    #1 reset = 1'b1;
    #2;
    check("rst_gnt0", 32'(gnt0_w[0]), 32'd0);
    check("rst_gnt1", 32'(gnt1_w[0]), 32'd0);
    check("rst_ctl", 32'(ctl_w[0]), 32'h8);
    check("rst_busy", 32'({busy0_w[0], busy1_w[0]}), 32'h3);
    check("rst_abort1", 32'(abort1_w[0]), 32'd0);
    to_pos(); to_pos();
    reset = 1'b0;

    // T1: single request from client 0
    req0 = 1'b1; ctl0 = 4'b0110; dat0 = 16'hA5A5; key0 = 2'b10;
    to_neg();
    check("t1_gnt0_before", 32'(gnt0_w[0]), 32'd0);
    check("t1_ctl_idle", 32'(ctl_w[0]), 32'h8);
    to_pos(); to_neg();
    check("t1_gnt0", 32'(gnt0_w[0]), 32'd1);
    check("t1_data", 32'(data_w[0]), 32'hA5A5);
    check("t1_ctl", 32'(ctl_w[0]), 32'h6);
    check("t1_busy1", 32'(busy1_w[0]), 32'd1);
    to_pos();
    req0 = 1'b0; ctl0 = 4'b0000;
    to_pos(); to_neg();
    check("t1_scrub_ctl", 32'(ctl_w[0]), 32'h8);
    to_pos();

    // T2: simultaneous requests after reset (last=1) -> client 0 first, then client 1
    do_reset();
    req0 = 1'b1; req1 = 1'b1; ctl0 = 4'b0010; ctl1 = 4'b0100; dat1 = 16'h5A5A;
    to_pos(); to_neg();
    check("t2_gnt0", 32'(gnt0_w[0]), 32'd1);
    check("t2_gnt1_blocked", 32'(gnt1_w[0]), 32'd0);
    to_pos();
    req0 = 1'b0;
    to_pos(); to_neg();
    check("t2_scrub", 32'({gnt0_w[0], gnt1_w[0], ctl_w[0]}), 32'h08);
    to_pos(); to_neg();
    check("t2_idle_gap", 32'(gnt1_w[0]), 32'd0);
    to_pos(); to_neg();
    check("t2_gnt1", 32'(gnt1_w[0]), 32'd1);
    check("t2_ctl1", 32'(ctl_w[0]), 32'h4);

    // T3: owner releases while core busy for 5 clocks -> DRAIN then SCRUB
    to_pos();
    req1 = 1'b0; hmac_busy = 1'b1;
    to_pos();
    for (int k = 0; k < 5; k++) begin
      to_neg();
      check($sformatf("t3_drain_ctl%0d", k), 32'(ctl_w[0]), 32'h0);
      to_pos();
      if (k == 3) hmac_busy = 1'b0;
    end
    to_neg();
    check("t3_scrub_ctl", 32'(ctl_w[0]), 32'h8);
    to_pos();

    // T4: fixed priority starves client 1 across three client-0 sessions
    do_reset();
    req0 = 1'b1; req1 = 1'b1; ctl1 = 4'b0000;
    for (int s = 0; s < 3; s++) begin
      to_pos(); to_neg();
      check($sformatf("t4_fp_gnt0_s%0d", s), 32'(gnt0_w[1]), 32'd1);
      check($sformatf("t4_fp_gnt1_s%0d", s), 32'(gnt1_w[1]), 32'd0);
      to_pos();
      req0 = 1'b0;
      to_pos();
      req0 = (s < 2);
      to_pos();
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      to_neg();
      if (gnt1_w[1]) seen = 1'b1;
      else to_pos();
    end
    check("t4_fp_gnt1_final", 32'(seen), 32'd1);
    req1 = 1'b0;
    repeat (4) to_pos();

    // T5: client 1 idles while owning the core
    do_reset();
    req0 = 1'b0; req1 = 1'b1; ctl1 = 4'b0000; hmac_busy = 1'b0;
    to_pos();
`ifdef HMAC_ARB_TIMEOUT_EN
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      to_neg();
      if (!gnt1_w[0]) break;
      cnt++;
      to_pos();
    end
    check("t5_own_cycles", 32'(cnt), 32'd8);
    check("t5_abort1", 32'(abort1_w[0]), 32'd1);
    check("t5_scrub_ctl", 32'(ctl_w[0]), 32'h8);
    to_pos(); to_neg();
    check("t5_abort1_pulse", 32'(abort1_w[0]), 32'd0);
    repeat (3) to_pos();
    to_neg();
    check("t5_lock", 32'(gnt1_w[0]), 32'd0);
    req1 = 1'b0;
    to_pos();
    req1 = 1'b1;
    to_pos(); to_neg();
    check("t5_regrant", 32'(gnt1_w[0]), 32'd1);
`else
    cnt = 0; seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      to_neg();
      if (gnt1_w[0]) cnt++;
      if (abort1_w[0]) seen = 1'b1;
      to_pos();
    end
    check("t5_no_timeout_own", 32'(cnt), 32'd20);
    check("t5_no_abort", 32'(seen), 32'd0);
`endif

    // T6: asynchronous reset in the middle of a client-1 block
    to_pos();
    ctl1 = 4'b0110; dat1 = 16'h1234; hmac_busy = 1'b1;
    to_neg();
    check("t6_gnt1_pre", 32'(gnt1_w[0]), 32'd1);
    check("t6_data_pre", 32'(data_w[0]), 32'h1234);
    #2 reset = 1'b1;
    #1;
    check("t6_gnt1_rst", 32'(gnt1_w[0]), 32'd0);
    check("t6_ctl_rst", 32'(ctl_w[0]), 32'h8);
    check("t6_busy1_rst", 32'(busy1_w[0]), 32'd1);
    to_pos();
    reset = 1'b0; req1 = 1'b0; ctl1 = 4'b0000; hmac_busy = 1'b0;
    to_pos(); to_neg();
    check("t6_idle_after", 32'({gnt0_w[0], gnt1_w[0]}), 32'd0);
    to_pos(); to_pos();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
